if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined MIPS core. Owns the PC register, drives the instruction-memory

---
 rtl/if_fetch_stage.sv | 146 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the pipelined MIPS core. Holds the PC, runs the
//   instruction-memory request/ready handshake and fills the IF/ID register.
//   Fetches at most one instruction per cycle. It supports a decode stall, and
//   a branch/jump flush that redirects the PC to npc.
//
//   Ports
//     clk, rst            clock (rising edge), async active-high reset
//     npc                 next PC (redirect target when flush=1), low 2 bits ignored
//     stall, flush        decode back-pressure / taken branch-jump redirect
//     pc_out, pc_plus4    current PC and PC+4 for the next-PC logic
//     imem_req/addr       fetch request and word-aligned address
//     imem_ready/rdata    fetch completes this cycle with rdata
//     ifid_*              IF/ID pipeline register (valid, pc, pc+4, instr)
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr
);

    // REQ:   fetch of r_pc outstanding
    // HOLD:  word fetched but decode stalled, kept in r_hold_instr
    // DRAIN: a flushed fetch is still outstanding; its data is thrown away
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic [31:0] r_hold_instr;
    logic        r_imem_req;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_instr;

    logic [31:0] w_pc4;
    logic [31:0] w_npc_al;
    logic        w_unused_npc_lo;

    assign w_pc4           = r_pc + 32'd4;
    assign w_npc_al        = {npc[31:2], 2'b00};
    assign w_unused_npc_lo = ^npc[1:0];

    assign pc_out     = r_pc;
    assign pc_plus4   = w_pc4;
    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_instr = r_ifid_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_hold_instr <= '0;
            r_imem_req   <= 1'b1;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_instr <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ready) begin
                        if (flush) begin
                            r_pc         <= w_npc_al;
                            r_ifid_valid <= 1'b0;
                        end else if (stall) begin
                            // park the word; the request is done so drop imem_req
                            r_hold_instr <= imem_rdata;
                            r_imem_req   <= 1'b0;
                            r_state      <= S_HOLD;
                        end else begin
                            r_ifid_valid <= 1'b1;
                            r_ifid_pc    <= r_pc;
                            r_ifid_pc4   <= w_pc4;
                            r_ifid_instr <= imem_rdata;
                            r_pc         <= w_npc_al;
                        end
                    end else begin
                        if (flush) begin
                            // the memory still owes us this word; keep the
                            // address on the bus and remember where to go next
                            r_pend_pc    <= w_npc_al;
                            r_ifid_valid <= 1'b0;
                            r_state      <= S_DRAIN;
                        end else if (!stall) begin
                            r_ifid_valid <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        r_hold_instr <= '0;
                        r_pc         <= w_npc_al;
                        r_ifid_valid <= 1'b0;
                        r_imem_req   <= 1'b1;
                        r_state      <= S_REQ;
                    end else if (!stall) begin
                        r_ifid_valid <= 1'b1;
                        r_ifid_pc    <= r_pc;
                        r_ifid_pc4   <= w_pc4;
                        r_ifid_instr <= r_hold_instr;
                        r_pc         <= w_npc_al;
                        r_imem_req   <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    r_ifid_valid <= 1'b0;
                    if (imem_ready) begin
                        // a flush arriving in the same cycle is the newest redirect
                        r_pc    <= flush ? w_npc_al : r_pend_pc;
                        r_state <= S_REQ;
                    end else if (flush) begin
                        r_pend_pc <= w_npc_al;
                    end
                end
                default: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        stall, flush;
    logic [31:0] pc_out, pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_pc4, ifid_instr;

    logic        ovr_en;
    logic [31:0] ovr_val;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .npc(npc), .stall(stall), .flush(flush),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    // instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
    endfunction

    always_comb imem_rdata = ovr_en ? ovr_val : mem_f(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive inputs at the negedge, let one posedge pass, return at the next negedge
    task automatic apply(input logic s, input logic f, input logic r, input logic [31:0] n);
        stall = s; flush = f; imem_ready = r; npc = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 0; flush = 0; imem_ready = 0; npc = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, 32'h3000);
        chk("rst_pc4", pc_plus4, 32'h3004);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h3000);
    endtask

    typedef struct {
        logic        s, f, r;
        logic [31:0] npc;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_v;
        logic [31:0] e_ifpc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic r,
                                input logic [31:0] n, input logic [31:0] epc,
                                input logic ereq, input logic ev, input logic [31:0] eif);
        vec_t v;
        v.s = s; v.f = f; v.r = r; v.npc = n;
        v.e_pc = epc; v.e_req = ereq; v.e_v = ev; v.e_ifpc = eif;
        return v;
    endfunction

    // checks for the IF/ID entry holding the instruction fetched from address a
    task automatic chk_ifid(input string tag, input logic [31:0] a, input logic [31:0] instr);
        chk({tag, "_v"}, {31'b0, ifid_valid}, 32'h1);
        chk({tag, "_ifpc"}, ifid_pc, a);
        chk({tag, "_ifpc4"}, ifid_pc4, a + 32'd4);
        chk({tag, "_instr"}, ifid_instr, instr);
    endtask

    vec_t tbl[15];

    // reference model state for the random phase
    logic [31:0] m_pc, m_target, m_buf_instr, e_pc, e_instr, word, tgt;
    logic        m_buf_valid, m_stale, e_v, have;
    logic        rs, rf, rr;
    logic [31:0] rn;

    initial begin
        rst = 1'b1; stall = 0; flush = 0; imem_ready = 0; npc = 0;
        ovr_en = 0; ovr_val = 0;

        //            s  f  r  npc            pc            req v  ifid_pc
        tbl[0]  = mk(0, 0, 1, 32'h3004,     32'h3004,     1, 1, 32'h3000);
        tbl[1]  = mk(0, 0, 0, 32'h3008,     32'h3004,     1, 0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h3008,     32'h3004,     1, 0, 32'h0);
        tbl[3]  = mk(0, 0, 1, 32'h3008,     32'h3008,     1, 1, 32'h3004);
        tbl[4]  = mk(0, 0, 1, 32'h300c,     32'h300c,     1, 1, 32'h3008);
        tbl[5]  = mk(0, 1, 0, 32'h3ff0,     32'h300c,     1, 0, 32'h0);
        tbl[6]  = mk(1, 1, 0, 32'h4000,     32'h300c,     1, 0, 32'h0);
        tbl[7]  = mk(1, 0, 0, 32'h3010,     32'h300c,     1, 0, 32'h0);
        tbl[8]  = mk(0, 0, 1, 32'h3010,     32'h4000,     1, 0, 32'h0);
        tbl[9]  = mk(0, 0, 1, 32'h4004,     32'h4004,     1, 1, 32'h4000);
        tbl[10] = mk(1, 0, 1, 32'h4008,     32'h4004,     0, 1, 32'h4000);
        tbl[11] = mk(1, 0, 0, 32'h4008,     32'h4004,     0, 1, 32'h4000);
        tbl[12] = mk(0, 0, 0, 32'h4008,     32'h4008,     1, 1, 32'h4004);
        tbl[13] = mk(0, 1, 1, 32'h5003,     32'h5000,     1, 0, 32'h0);
        tbl[14] = mk(0, 0, 1, 32'h5004,     32'h5004,     1, 1, 32'h5000);

        do_reset();

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].s, tbl[i].f, tbl[i].r, tbl[i].npc);
            chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].e_pc);
            chk($sformatf("tbl%0d_pc4", i), pc_plus4, tbl[i].e_pc + 32'd4);
            chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_pc);
            chk($sformatf("tbl%0d_v", i), {31'b0, ifid_valid}, {31'b0, tbl[i].e_v});
            if (tbl[i].e_v) chk_ifid($sformatf("tbl%0d", i), tbl[i].e_ifpc, mem_f(tbl[i].e_ifpc));
        end

        // stall while the word arrives: hold for 4 cycles, then deliver it
        ovr_en = 1; ovr_val = 32'h2408_0005;
        apply(1, 0, 1, 32'h5008);
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_pc", pc_out, 32'h5004);
        ovr_val = 32'hdead_beef;
        for (int k = 0; k < 4; k++) begin
            apply(1, 0, k[0], 32'h5008);
            chk("hold_req_k", {31'b0, imem_req}, 32'h0);
            chk_ifid("hold_k", 32'h5000, mem_f(32'h5000));
        end
        apply(0, 0, 0, 32'h5008);
        chk("rel_pc", pc_out, 32'h5008);
        chk_ifid("rel", 32'h5004, 32'h2408_0005);
        ovr_en = 0;

        // flush and stall together in HOLD: the flush wins
        apply(1, 0, 1, 32'h500c);
        chk("hold2_req", {31'b0, imem_req}, 32'h0);
        apply(1, 1, 0, 32'h6000);
        chk("hf_pc", pc_out, 32'h6000);
        chk("hf_v", {31'b0, ifid_valid}, 32'h0);
        chk("hf_req", {31'b0, imem_req}, 32'h1);
        apply(0, 0, 1, 32'h6004);
        chk_ifid("hf_next", 32'h6000, mem_f(32'h6000));

        // reset while a flushed fetch drains
        apply(0, 1, 0, 32'h7000);
        chk("dr_pc", pc_out, 32'h6004);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", pc_out, 32'h3000);
        chk("async_rst_v", {31'b0, ifid_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(0, 0, 1, 32'h3004);
        chk("after_rst_pc", pc_out, 32'h3004);
        chk_ifid("after_rst", 32'h3000, mem_f(32'h3000));

        // PC+4 wraps at 2^32
        apply(0, 0, 1, 32'hffff_fffe);
        chk("wrap_pc", pc_out, 32'hffff_fffc);
        chk("wrap_pc4", pc_plus4, 32'h0);
        apply(0, 0, 1, 32'h0);
        chk("wrap_pc_next", pc_out, 32'h0);
        chk_ifid("wrap", 32'hffff_fffc, mem_f(32'hffff_fffc));

        // randomized run against a transaction-level model
        do_reset();
        m_pc = 32'h3000; m_buf_valid = 0; m_buf_instr = 0; m_stale = 0; m_target = 0;
        e_v = 0; e_pc = 0; e_instr = 0;
        for (int c = 0; c < 1500; c++) begin
            chk("rnd_pc", pc_out, m_pc);
            chk("rnd_pc4", pc_plus4, m_pc + 32'd4);
            chk("rnd_req", {31'b0, imem_req}, {31'b0, !m_buf_valid});
            if (!m_buf_valid) chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_v", {31'b0, ifid_valid}, {31'b0, e_v});
            if (e_v) chk_ifid("rnd", e_pc, e_instr);

            rs = ($urandom_range(0, 99) < 30);
            rf = ($urandom_range(0, 99) < 12);
            rr = ($urandom_range(0, 99) < 60);
            rn = rf ? $urandom : m_pc + 32'd4;
            tgt = {rn[31:2], 2'b00};

            if (m_stale) begin
                // a squashed fetch is in flight; its data never reaches decode
                if (rf) m_target = tgt;
                if (rr) begin m_pc = m_target; m_stale = 0; end
                e_v = 0;
            end else begin
                have = m_buf_valid || rr;
                word = m_buf_valid ? m_buf_instr : mem_f(m_pc);
                if (rf) begin
                    e_v = 0;
                    if (have) begin m_pc = tgt; m_buf_valid = 0; end
                    else begin m_stale = 1; m_target = tgt; end
                end else if (rs) begin
                    if (have) begin m_buf_valid = 1; m_buf_instr = word; end
                end else if (have) begin
                    e_v = 1; e_pc = m_pc; e_instr = word;
                    m_pc = tgt; m_buf_valid = 0;
                end else begin
                    e_v = 0;
                end
            end
            apply(rs, rf, rr, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
